if_id_queue: RTL and testbench
==============================

IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of entries; a power of two, at least 2.
REQ-002 SHALL have parameter WIDTH, default 32: bit width of both PC and instruction.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port enq_valid, input, 1: the fetch side offers one entry this cycle.
REQ-006 SHALL have port enq_ready, output, 1: the queue accepts an entry this cycle.
REQ-007 SHALL have port enq_pc, input, WIDTH: PC of the offered instruction.
REQ-008 SHALL have port enq_inst, input, WIDTH: the offered instruction word.
REQ-009 SHALL have port deq_valid, output, 1: the head entry is valid.
REQ-010 SHALL have port deq_ready, input, 1: the decode side consumes the head this cycle.
REQ-011 SHALL have port deq_pc, output, WIDTH: PC of the head entry.
REQ-012 SHALL have port deq_inst, output, WIDTH: instruction word of the head entry.
REQ-013 SHALL have port flush, input, 1: redirect taken; discard all entries.
REQ-014 SHALL have port count, output, $clog2(DEPTH)+1: current number of valid entries.

Function
REQ-015 SHALL accept an entry (enq fire) on a rising edge where enq_valid=1 and enq_ready=1.
REQ-016 SHALL consume the head (deq fire) on a rising edge where deq_valid=1 and deq_ready=1.
REQ-017 SHALL drive enq_ready = (count != DEPTH), combinationally from state only, never from deq_ready.
REQ-018 SHALL drive deq_valid = (count != 0).
REQ-019 SHALL have no bypass: an entry accepted at edge N first appears at deq_* after edge N, with one cycle of latency.
REQ-020 SHALL keep strict FIFO order; each accepted entry is delivered exactly once unless flushed.
REQ-021 SHALL drive deq_pc and deq_inst from the head storage slot; their values are don't-care while deq_valid=0.
REQ-022 SHALL use read and write pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0 with no gap.
REQ-023 SHALL update count as +1 on enq only, -1 on deq only, and unchanged on simultaneous enq and deq.
REQ-024 SHALL, when full with deq fire, not accept enq in the same cycle (enq_ready was 0); count becomes DEPTH-1.
REQ-025 SHALL, when empty, accept enq while deq is impossible; count becomes 1.
REQ-026 SHALL give flush priority over enq and deq: on an edge with flush=1, pointers and count go to 0 and the enq data is dropped.
REQ-027 SHALL not have flush gate enq_ready or deq_valid combinationally in its own cycle; the effect is visible after the edge.
REQ-028 SHALL leave storage contents unchanged on flush; only pointers and count are affected.
REQ-029 SHALL never let count exceed DEPTH or underflow below 0.

Reset
REQ-030 SHALL, while reset=1 and without any clock edge, set read pointer=0, write pointer=0, count=0, deq_valid=0 and enq_ready=1.
REQ-031 SHALL, when reset asserts mid-operation, lose all entries immediately; the first edge after release behaves as in the empty state.
REQ-032 SHALL leave storage contents unreset.

Verification
REQ-033 Reset check: reset pulse asserted with no clock edge -> count=0, deq_valid=0, enq_ready=1 immediately.
REQ-034 Fill check (DEPTH=4): enq PC 0x00,0x04,0x08,0x0C with inst 0xA0..0xA3 and deq_ready=0 -> count=4, enq_ready=0; then deq_ready=1 -> PCs delivered in order 0x00..0x0C, one per cycle.
REQ-035 Wrap check: 10 enq with random deq_ready -> all 10 PCs delivered in order across pointer wrap; count never exceeds 4.
REQ-036 Full boundary check: full queue, enq_valid=1 and deq_ready=1 in one cycle -> count=3 and the enq is not accepted; next cycle enq_ready=1 and the accept gives count=4.
REQ-037 Flush check: count=3, flush=1 with enq_valid=1 (PC 0x40) -> next cycle count=0, deq_valid=0; PC 0x40 is never delivered.
REQ-038 Latency check: empty queue, enq of PC 0x100 at edge N -> deq_valid=0 before edge N, deq_valid=1 with deq_pc=0x100 after edge N.

Source files
------------

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: a DEPTH-entry FIFO of (PC, instruction) pairs
// with valid/ready handshakes on both sides and a flush that empties it on a redirect.
module if_id_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [WIDTH-1:0]           enq_pc,
  input  logic [WIDTH-1:0]           enq_inst,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [WIDTH-1:0]           deq_pc,
  output logic [WIDTH-1:0]           deq_inst,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] pc_mem   [DEPTH];
  logic [WIDTH-1:0] inst_mem [DEPTH];

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            enq_fire, deq_fire;

  // Handshake outputs depend on registered state only; flush acts after the edge.
  assign enq_ready = (count_q != CntW'(DEPTH));
  assign deq_valid = (count_q != '0);
  assign enq_fire  = enq_valid & enq_ready;
  assign deq_fire  = deq_valid & deq_ready;

  assign deq_pc   = pc_mem[rd_ptr_q];
  assign deq_inst = inst_mem[rd_ptr_q];
  assign count    = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Power-of-two depth lets the pointers wrap by plain overflow.
      if (enq_fire) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (deq_fire) rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({enq_fire, deq_fire})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset and untouched by flush.
  always_ff @(posedge clk) begin
    if (enq_fire && !flush) begin
      pc_mem[wr_ptr_q]   <= enq_pc;
      inst_mem[wr_ptr_q] <= enq_inst;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: a queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_if_id_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             enq_valid, deq_ready, flush;
  logic             enq_ready, deq_valid;
  logic [WIDTH-1:0] enq_pc, enq_inst, deq_pc, deq_inst;
  logic [2:0]       count;

  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH-1:0] m_pc[$];
  logic [WIDTH-1:0] m_inst[$];
  logic [WIDTH-1:0] log_pc[$];

  if_id_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .enq_pc    (enq_pc),
    .enq_inst  (enq_inst),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .deq_pc    (deq_pc),
    .deq_inst  (deq_inst),
    .flush     (flush),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO semantics straight from the handshake rules.
  always @(posedge clk or posedge reset) begin
    if (reset || flush) begin
      m_pc.delete();
      m_inst.delete();
    end else begin
      automatic bit ef = enq_valid && (m_pc.size() < DEPTH);
      automatic bit df = deq_ready && (m_pc.size() > 0);
      if (df) begin
        log_pc.push_back(m_pc[0]);
        void'(m_pc.pop_front());
        void'(m_inst.pop_front());
      end
      if (ef) begin
        m_pc.push_back(enq_pc);
        m_inst.push_back(enq_inst);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("count", 64'(count), 64'(m_pc.size()));
      chk("count_bound", 64'(count <= 3'(DEPTH)), 64'd1);
      chk("deq_valid", 64'(deq_valid), 64'(m_pc.size() != 0));
      chk("enq_ready", 64'(enq_ready), 64'(m_pc.size() != DEPTH));
      if (m_pc.size() != 0) begin
        chk("deq_pc", 64'(deq_pc), 64'(m_pc[0]));
        chk("deq_inst", 64'(deq_inst), 64'(m_inst[0]));
      end
    end
  end

  // Advance one edge; inputs change 2 time units after it.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    flush     = 1'b0;
    enq_pc    = '0;
    enq_inst  = '0;
  endtask

  task automatic enq_one(input logic [WIDTH-1:0] pc, input logic [WIDTH-1:0] inst);
    enq_valid = 1'b1;
    enq_pc    = pc;
    enq_inst  = inst;
    step();
    enq_valid = 1'b0;
  endtask

  task automatic drain();
    deq_ready = 1'b1;
    for (int i = 0; i < 20 && m_pc.size() != 0; i++) step();
    chk("drain_done", 64'(m_pc.size()), 64'd0);
    deq_ready = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    #3;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_deq_valid", 64'(deq_valid), 64'd0);
    chk("rst_enq_ready", 64'(enq_ready), 64'd1);
    step();
    step();
    reset = 1'b0;

    // Fill then drain in order.
    for (int i = 0; i < 4; i++) enq_one(32'(i * 4), 32'(32'hA0 + i));
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_enq_ready", 64'(enq_ready), 64'd0);
    log_pc.delete();
    drain();
    chk("fill_log_size", 64'(log_pc.size()), 64'd4);
    for (int i = 0; i < 4 && i < log_pc.size(); i++)
      chk("fill_order", 64'(log_pc[i]), 64'(i * 4));

    // Ten entries with random back-pressure, crossing the pointer wrap.
    log_pc.delete();
    begin
      int k = 0;
      for (int c = 0; c < 300 && k < 10; c++) begin
        automatic bit acc = (m_pc.size() < DEPTH);
        enq_valid = 1'b1;
        enq_pc    = 32'(32'h200 + 4 * k);
        enq_inst  = 32'(32'hB0 + k);
        deq_ready = 1'($urandom_range(0, 1));
        step();
        if (acc) k++;
      end
      chk("wrap_all_accepted", 64'(k), 64'd10);
    end
    enq_valid = 1'b0;
    drain();
    chk("wrap_log_size", 64'(log_pc.size()), 64'd10);
    for (int i = 0; i < 10 && i < log_pc.size(); i++)
      chk("wrap_order", 64'(log_pc[i]), 64'(32'h200 + 4 * i));

    // Full queue: simultaneous enq offer and deq must not accept the enq.
    log_pc.delete();
    for (int i = 0; i < 4; i++) enq_one(32'(32'h300 + 4 * i), 32'(32'hC0 + i));
    enq_valid = 1'b1;
    enq_pc    = 32'h310;
    enq_inst  = 32'hC4;
    deq_ready = 1'b1;
    step();
    deq_ready = 1'b0;
    chk("full_deq_count", 64'(count), 64'd3);
    chk("full_next_ready", 64'(enq_ready), 64'd1);
    step();
    enq_valid = 1'b0;
    chk("full_reaccept_count", 64'(count), 64'd4);
    drain();
    chk("full_log_size", 64'(log_pc.size()), 64'd5);
    for (int i = 0; i < 5 && i < log_pc.size(); i++)
      chk("full_order", 64'(log_pc[i]), 64'(32'h300 + 4 * i));

    // Flush wins over a concurrent enq.
    log_pc.delete();
    for (int i = 0; i < 3; i++) enq_one(32'(32'h500 + 4 * i), 32'(32'hD0 + i));
    chk("pre_flush_count", 64'(count), 64'd3);
    flush     = 1'b1;
    enq_valid = 1'b1;
    enq_pc    = 32'h40;
    enq_inst  = 32'hEE;
    step();
    flush     = 1'b0;
    enq_valid = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_deq_valid", 64'(deq_valid), 64'd0);
    deq_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    deq_ready = 1'b0;
    chk("flush_nothing_delivered", 64'(log_pc.size()), 64'd0);

    // One cycle of latency, no bypass.
    chk("lat_pre_empty", 64'(deq_valid), 64'd0);
    enq_valid = 1'b1;
    enq_pc    = 32'h100;
    enq_inst  = 32'h13;
    deq_ready = 1'b1;
    #1;
    chk("lat_before_edge", 64'(deq_valid), 64'd0);
    step();
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    chk("lat_after_valid", 64'(deq_valid), 64'd1);
    chk("lat_after_pc", 64'(deq_pc), 64'h100);

    // Asynchronous reset mid-operation clears everything without an edge.
    enq_one(32'h600, 32'hF0);
    chk("mid_count", 64'(count), 64'd2);
    reset = 1'b1;
    #1;
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_deq_valid", 64'(deq_valid), 64'd0);
    chk("mid_rst_enq_ready", 64'(enq_ready), 64'd1);
    step();
    reset = 1'b0;
    log_pc.delete();
    enq_one(32'h700, 32'hF1);
    chk("post_rst_count", 64'(count), 64'd1);
    drain();
    chk("post_rst_log_size", 64'(log_pc.size()), 64'd1);
    if (log_pc.size() != 0) chk("post_rst_pc", 64'(log_pc[0]), 64'h700);

    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
